// File: rtl/mac_accumulator.sv
// Signed fixed-point dot-product engine: a product register feeding a wide accumulator,
// one saturated frame sum per VEC_LEN operand pairs, handed to the rounder over a valid/ready port.
module mac_accumulator #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int VEC_LEN        = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [para_int_bits+para_frac_bits-1:0]         in_a,
    input  logic [para_int_bits+para_frac_bits-1:0]         in_b,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [2*(para_int_bits+para_frac_bits)-1:0]     out_sum,
    output logic                                            out_ovf
);
    localparam int W  = para_int_bits + para_frac_bits;
    localparam int PW = 2 * W;
    localparam int AW = PW + $clog2(VEC_LEN);
    localparam int CW = $clog2(VEC_LEN);

    localparam logic [CW-1:0]        CNT_LAST = CW'(VEC_LEN - 1);
    localparam logic signed [AW-1:0] SUM_MAX  = {{(AW-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN  = {{(AW-PW+1){1'b1}}, {(PW-1){1'b0}}};

    logic [CW-1:0]        cnt;
    logic signed [PW-1:0] a_ext, b_ext, p;
    logic                 p_valid, p_last;
    logic signed [AW-1:0] acc, p_ext, total;
    logic                 stall, accept, load, too_big, too_small;

    assign a_ext = PW'($signed(in_a));
    assign b_ext = PW'($signed(in_b));

    // Only a finished sum with nowhere to go can block the pipe; partial terms always drain.
    assign stall    = p_valid & p_last & out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign load     = p_valid & p_last & ~stall;

    assign p_ext     = {{(AW-PW){p[PW-1]}}, p};
    assign total     = acc + p_ext;
    assign too_big   = total > SUM_MAX;
    assign too_small = total < SUM_MIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            p         <= '0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (!stall) begin
                p_valid <= accept;
                if (accept) begin
                    p      <= a_ext * b_ext;
                    p_last <= (cnt == CNT_LAST);
                    cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                end
                if (p_valid) begin
                    acc <= p_last ? '0 : total;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_ovf   <= too_big | too_small;
                if (too_big)
                    out_sum <= SUM_MAX[PW-1:0];
                else if (too_small)
                    out_sum <= SUM_MIN[PW-1:0];
                else
                    out_sum <= total[PW-1:0];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (W=16, VEC_LEN=8): a table of uniform frames with latency
// checks, then hand-written back-pressure, mid-frame reset and continuous-stream sequences.
module tb_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [15:0] in_a, in_b;
    logic [31:0] out_sum;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        int          cyc;
    } out_t;

    vec_t tbl[7];
    out_t oq[$];

    mac_accumulator #(.para_int_bits(7), .para_frac_bits(9), .VEC_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so at negedge out_ready is the value the next edge samples.
    always @(negedge clk)
        if (!rst && out_valid && out_ready) oq.push_back('{out_sum, out_ovf, cyc});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{16'h0200, 16'h0200, 32'h0020_0000, 1'b0};
        tbl[1] = '{16'h8000, 16'h8000, 32'h7FFF_FFFF, 1'b1};
        tbl[2] = '{16'h8000, 16'h7FFF, 32'h8000_0000, 1'b1};
        tbl[3] = '{16'h0200, 16'hFE00, 32'hFFE0_0000, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, 1'b1};
        tbl[5] = '{16'h0001, 16'hFFFF, 32'hFFFF_FFF8, 1'b0};
        tbl[6] = '{16'h1000, 16'h1000, 32'h0800_0000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Uniform frames: sum, saturation flag and two-stage latency after the 8th accept.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 8; k++) send(tbl[i].a, tbl[i].b);
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("row%0d_early", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("row%0d_sum", i), out_sum, tbl[i].sum);
            chk($sformatf("row%0d_ovf", i), 32'(out_ovf), 32'(tbl[i].ovf));
            idle(1);
        end

        // Back-pressure: frame 1 (1.0*1.0) held, frame 2 (2.0*1.0) stalls in P until released.
        oq.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(k < 8 ? 16'h0200 : 16'h0400, 16'h0200);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_held_sum", out_sum, 32'h0020_0000);
        idle(3);
        @(negedge clk);
        chk("bp_still_held", out_sum, 32'h0020_0000);
        chk("bp_none_taken", 32'(oq.size()), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        idle(4);
        chk("bp_count", 32'(oq.size()), 32'd2);
        if (oq.size() >= 2) begin
            chk("bp_first", oq[0].sum, 32'h0020_0000);
            chk("bp_second", oq[1].sum, 32'h0040_0000);
            chk("bp_back_to_back", 32'(oq[1].cyc - oq[0].cyc), 32'd1);
        end

        // Reset mid-frame discards the partial sum; the next pair starts a fresh frame.
        oq.delete();
        for (int k = 0; k < 3; k++) send(16'h0200, 16'h0200);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        chk("mid_rst_quiet", 32'(oq.size()), 32'd0);
        for (int k = 0; k < 8; k++) send(16'h0200, 16'h0200);
        in_valid = 1'b0;
        idle(4);
        chk("mid_rst_count", 32'(oq.size()), 32'd1);
        if (oq.size() >= 1) chk("mid_rst_sum", oq[0].sum, 32'h0020_0000);

        // Continuous stream of +1/-1 products: three zero sums, one every 8 cycles.
        oq.delete();
        for (int k = 0; k < 24; k++) send(16'h0200, (k % 2 == 1) ? 16'hFE00 : 16'h0200);
        in_valid = 1'b0;
        idle(4);
        chk("stream_count", 32'(oq.size()), 32'd3);
        if (oq.size() >= 3) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("stream%0d_sum", j), oq[j].sum, 32'd0);
                chk($sformatf("stream%0d_ovf", j), 32'(oq[j].ovf), 32'd0);
            end
            chk("stream_gap0", 32'(oq[1].cyc - oq[0].cyc), 32'd8);
            chk("stream_gap1", 32'(oq[2].cyc - oq[1].cyc), 32'd8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
